// File: rtl/serial_sum_ctrl_pkg.sv
// Shared definitions for the serial summing controller: default sizes,
// controller state encoding and the operand-count clamp.
package serial_sum_ctrl_pkg;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_SUMWIDTH  = 32;
  localparam int unsigned DEF_MAXOPS    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [4:0] clamp_ops(input logic [4:0] n, input logic [4:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/serial_sum_ctrl_add.sv
// Plain modulo-2^WIDTH adder used as the accumulation datapath.
module ADD #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/serial_sum_ctrl.sv
// Job-based serial accumulator: takes NumOps operands over a valid/ready
// stream, then holds the total on Sum until the consumer handshakes it.
module serial_sum_ctrl
  import serial_sum_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned SUMWIDTH  = DEF_SUMWIDTH,
  parameter int unsigned MAXOPS    = DEF_MAXOPS
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [4:0]           NumOps,
  input  logic [DATAWIDTH-1:0] InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [SUMWIDTH-1:0]  Sum,
  output logic                 SumValid,
  input  logic                 SumReady,
  output logic                 Busy
);

  state_t                state_q, state_d;
  logic [SUMWIDTH-1:0]   acc_q, acc_d;
  logic [SUMWIDTH-1:0]   sum_q, sum_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            ops_clamped;
  logic [SUMWIDTH-1:0]   add_res;

  assign ops_clamped = clamp_ops(NumOps, 5'(MAXOPS));

  ADD #(.WIDTH(SUMWIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (SUMWIDTH'(InData)),
    .sum_o (add_res)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (ops_clamped == 5'd0) begin
            sum_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = ops_clamped;
            acc_d   = '0;
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (InValid) begin
          acc_d = add_res;
          cnt_d = cnt_q - 5'd1;
          // Last operand goes straight into the result register.
          if (cnt_q == 5'd1) begin
            sum_d   = add_res;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (SumReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InReady  = (state_q == S_ACCUM);
  assign SumValid = (state_q == S_DONE);
  assign Busy     = (state_q != S_IDLE);
  assign Sum      = sum_q;

endmodule

// File: tb/tb_serial_sum_ctrl.sv
// Self-checking bench for serial_sum_ctrl: job-level reference model compared
// every cycle, directed scenarios with literal totals, then random traffic.
module tb_serial_sum_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 32;
  localparam int unsigned MO = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [4:0]    NumOps;
  logic [DW-1:0] InData;
  logic          InValid;
  logic          InReady;
  logic [SW-1:0] Sum;
  logic          SumValid;
  logic          SumReady;
  logic          Busy;

  serial_sum_ctrl #(.DATAWIDTH(DW), .SUMWIDTH(SW), .MAXOPS(MO)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .NumOps   (NumOps),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady),
    .Sum      (Sum),
    .SumValid (SumValid),
    .SumReady (SumReady),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Job-level reference: a job is either collecting operands or holding a result.
  bit            m_collecting = 1'b0;
  bit            m_result     = 1'b0;
  int            m_left       = 0;
  longint        m_total      = 0;
  logic [SW-1:0] m_sum        = '0;
  int            m_req;

  always @(posedge Clk) begin
    if (Rst) begin
      m_collecting = 1'b0;
      m_result     = 1'b0;
      m_left       = 0;
      m_total      = 0;
      m_sum        = '0;
    end else if (m_result) begin
      if (SumReady) m_result = 1'b0;
    end else if (m_collecting) begin
      if (InValid) begin
        m_total = m_total + longint'(InData);
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_sum        = m_total[SW-1:0];
          m_collecting = 1'b0;
          m_result     = 1'b1;
        end
      end
    end else if (Start) begin
      m_req = (int'(NumOps) > int'(MO)) ? int'(MO) : int'(NumOps);
      if (m_req == 0) begin
        m_sum    = '0;
        m_result = 1'b1;
      end else begin
        m_collecting = 1'b1;
        m_left       = m_req;
        m_total      = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("model_InReady",  64'(InReady),  64'(m_collecting));
      check("model_SumValid", 64'(SumValid), 64'(m_result));
      check("model_Busy",     64'(Busy),     64'(m_collecting | m_result));
      check("model_Sum",      64'(Sum),      64'(m_sum));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_job(input logic [4:0] n);
    Start = 1'b1; NumOps = n; tick(); Start = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] d);
    InValid = 1'b1; InData = d; tick(); InValid = 1'b0;
  endtask

  task automatic handshake();
    SumReady = 1'b1; tick(); SumReady = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; NumOps = '0; InData = '0; InValid = 1'b0; SumReady = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset_InReady",  64'(InReady),  64'd0);
    check("reset_SumValid", 64'(SumValid), 64'd0);
    check("reset_Busy",     64'(Busy),     64'd0);
    check("reset_Sum",      64'(Sum),      64'd0);
    Rst = 1'b0;

    // 1..16 streamed continuously
    start_job(5'd16);
    check("seq_busy", 64'(Busy), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      check("seq_no_early_valid", 64'(SumValid), 64'd0);
      InValid = 1'b1; InData = DW'(i); tick();
    end
    InValid = 1'b0;
    check("seq_sumvalid", 64'(SumValid), 64'd1);
    check("seq_sum136",   64'(Sum),      64'd136);
    handshake();
    check("seq_idle", 64'(Busy), 64'd0);

    // back-to-back: Start on the cycle right after the handshake
    start_job(5'd16);
    for (int i = 0; i < 16; i++) begin
      InValid = 1'b1; InData = 8'd255; tick();
    end
    InValid = 1'b0;
    check("max_sum4080", 64'(Sum), 64'd4080);
    handshake();

    // gapped stream
    start_job(5'd3);
    feed(8'd10); tick(); feed(8'd20); tick(); feed(8'd30);
    check("gap_sum60", 64'(Sum), 64'd60);
    check("gap_valid", 64'(SumValid), 64'd1);
    handshake();

    // zero operands
    start_job(5'd0);
    check("zero_valid", 64'(SumValid), 64'd1);
    check("zero_sum",   64'(Sum),      64'd0);
    handshake();

    // oversize request clamps to 16 transfers
    start_job(5'd20);
    for (int i = 0; i < 16; i++) begin
      InValid = 1'b1; InData = 8'd1; tick();
    end
    InValid = 1'b0;
    check("clamp_valid", 64'(SumValid), 64'd1);
    check("clamp_sum16", 64'(Sum),      64'd16);
    feed(8'd99);
    check("clamp_no_extra", 64'(Sum), 64'd16);
    handshake();

    // stall in DONE with Start/InValid noise
    start_job(5'd2);
    feed(8'd3); feed(8'd4);
    for (int i = 0; i < 5; i++) begin
      Start = (i % 2 == 0); NumOps = 5'd4; InValid = 1'b1; InData = 8'd50; tick();
      check("stall_sum",   64'(Sum),      64'd7);
      check("stall_valid", 64'(SumValid), 64'd1);
    end
    InValid = 1'b0; Start = 1'b1; SumReady = 1'b1; tick();
    Start = 1'b0; SumReady = 1'b0;
    check("stall_release_idle", 64'(Busy), 64'd0);

    // reset mid-job
    start_job(5'd8);
    for (int i = 0; i < 5; i++) feed(DW'(i + 1));
    Rst = 1'b1; tick(); Rst = 1'b0;
    check("rst_busy",  64'(Busy),     64'd0);
    check("rst_ready", 64'(InReady),  64'd0);
    check("rst_valid", 64'(SumValid), 64'd0);
    check("rst_sum",   64'(Sum),      64'd0);
    repeat (3) begin
      tick();
      check("rst_no_pulse", 64'(SumValid), 64'd0);
    end
    start_job(5'd2);
    feed(8'd7); feed(8'd8);
    check("post_rst_sum15", 64'(Sum), 64'd15);
    handshake();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      Rst      = ($urandom_range(0, 150) == 0);
      Start    = ($urandom_range(0, 3) == 0);
      NumOps   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      InData   = DW'($urandom);
      InValid  = ($urandom_range(0, 3) != 0);
      SumReady = ($urandom_range(0, 2) == 0);
      tick();
    end
    Rst = 1'b0; Start = 1'b0; InValid = 1'b0; SumReady = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
